scale_demux: RTL and testbench
==============================

Name: scale_demux

Overview:
- Registered 1-to-2 demultiplexer; the inverse of the scale mux.
- A single input stream is steered to channel A or channel B by sel_a.
- Each output channel has a one-entry holding register and a valid/ready handshake.
- Each channel has a saturating transfer counter, so the block can sit between one producer and two independent consumers with backpressure.

Parameters:
- WIDTH, 1, data width of in_data, out_a and out_b.
- CNT_W, 8, width of the per-channel transfer counters cnt_a and cnt_b.

Ports:
- clk  input  1  rising-edge clock.
- rst_  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  input data word.
- in_valid  input  1  in_data valid this cycle.
- sel_a  input  1  1'b1 steers the word to channel A; 1'b0 steers it to channel B. Sampled with in_data.
- in_ready  output  1  block accepts the word this cycle.
- out_a  output  WIDTH  channel A data, registered.
- out_a_valid  output  1  channel A holding register full.
- out_a_ready  input  1  channel A consumer accepts.
- out_b  output  WIDTH  channel B data, registered.
- out_b_valid  output  1  channel B holding register full.
- out_b_ready  input  1  channel B consumer accepts.
- cnt_a  output  CNT_W  completed channel A output transfers, saturating.
- cnt_b  output  CNT_W  completed channel B output transfers, saturating.

Behaviour:
- Reset (rst_ low, asynchronous, any time):
  - out_a, out_b, cnt_a, cnt_b go to 0.
  - out_a_valid and out_b_valid go to 0.
  - A word held mid-transfer is discarded; nothing is replayed after reset.
- Per-channel state, two states per channel:
  - EMPTY: valid=0.
  - FULL: valid=1, data held stable.
- Input acceptance:
  - in_accept = in_valid & in_ready.
  - in_ready is combinational: (sel_a ? ready_path_a : ready_path_b).
  - ready_path_x = ~out_x_valid | out_x_ready.
  - in_ready depends only on the selected channel; a stalled unselected channel never blocks the input.
- Output transfer: out_x_fire = out_x_valid & out_x_ready.
- Channel X transitions, evaluated on each clk rising edge:
  - EMPTY, in_accept to X: load data, go to FULL.
  - FULL, out_x_fire and no load: go to EMPTY.
  - FULL, out_x_fire and simultaneous load: stay FULL with the new data. This is back-to-back pass-through at full throughput.
  - FULL, no fire: hold data and valid; an incoming word for X is not accepted (in_ready=0).
- Latency: one cycle from in_accept to out_x_valid.
- Steering and stability:
  - Only the selected channel loads; the other channel's register is untouched.
  - While valid=1 and ready=0, out_x must not change.
- Simultaneous events:
  - Both channels may fire in the same cycle while the input loads one of them.
  - Channel A and B counters update independently in the same cycle.
- Counters:
  - cnt_x increments by 1 on each out_x_fire.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by reset.
- When in_valid=0, sel_a and in_data are don't-care and cause no state change.
- Design rules: no combinational path from out_x_ready to out_x or out_x_valid; only in_ready is combinational.

Test Plan:
1. Reset mid-operation:
   - Stimulus: WIDTH=8. Load A with 8'h5A while out_a_ready=0, then pulse rst_ low asynchronously between clock edges.
   - Required: out_a_valid=0, out_a=0 and cnt_a=0 immediately. No transfer after rst_ releases.
2. Steering:
   - Stimulus: in_data=8'h11 with sel_a=1, then 8'h22 with sel_a=0, both consumers ready.
   - Required: out_a=8'h11 valid one cycle after its accept; out_b=8'h22 one cycle after its accept. cnt_a=1, cnt_b=1.
3. Backpressure on the selected channel:
   - Stimulus: out_a_ready=0, A FULL with 8'h33, second word for A presented.
   - Required: in_ready=0 and out_a holds 8'h33. After out_a_ready=1, the second word appears the next cycle and cnt_a increments by 1 per fire.
4. Independent stall:
   - Stimulus: B FULL with out_b_ready=0; stream 4 words to A with out_a_ready=1.
   - Required: in_ready=1 every cycle, all 4 words emerge on out_a in order, cnt_a=4. out_b stays unchanged and cnt_b is unchanged.
5. Full throughput:
   - Stimulus: 16 consecutive words to A with in_valid=1 and out_a_ready=1 throughout.
   - Required: one word per cycle with no bubbles, and cnt_a=16.
6. Counter saturation:
   - Stimulus: CNT_W=2, 5 transfers on B.
   - Required: cnt_b reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/scale_demux.sv
// ---------------------------------------------------------------------------
// scale_demux
//   Registered 1-to-2 demultiplexer. One input stream is steered to channel A
//   or channel B by sel_a. Each channel owns a one-entry holding register with
//   a valid/ready handshake and a saturating count of completed transfers.
//
// Ports
//   clk          rising-edge clock
//   rst_         asynchronous active-low reset
//   in_data      input word (WIDTH)
//   in_valid     in_data valid this cycle
//   sel_a        1: word goes to channel A, 0: word goes to channel B
//   in_ready     block accepts the word this cycle (combinational)
//   out_a        channel A data, registered (WIDTH)
//   out_a_valid  channel A holding register full
//   out_a_ready  channel A consumer accepts
//   out_b        channel B data, registered (WIDTH)
//   out_b_valid  channel B holding register full
//   out_b_ready  channel B consumer accepts
//   cnt_a        completed channel A transfers, saturating (CNT_W)
//   cnt_b        completed channel B transfers, saturating (CNT_W)
// ---------------------------------------------------------------------------
module scale_demux #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             sel_a,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_a,
   output logic             out_a_valid,
   input  logic             out_a_ready,
   output logic [WIDTH-1:0] out_b,
   output logic             out_b_valid,
   input  logic             out_b_ready,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } chan_state_t;

   chan_state_t      state_a_p1, state_b_p1;
   logic [WIDTH-1:0] data_a_p1, data_b_p1;
   logic [CNT_W-1:0] cnt_a_p1, cnt_b_p1;

   logic ready_path_a, ready_path_b;
   logic in_accept;
   logic load_a, load_b;
   logic fire_a, fire_b;

   // Increment that sticks at the all-ones value instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}})
         return v;
      else
         return v + CNT_W'(1);
   endfunction

   // A channel can take a new word when it is empty or when its current word
   // leaves in the same cycle. Only the selected channel gates the input, so a
   // stalled unselected consumer never blocks the producer.
   assign ready_path_a = (state_a_p1 == EMPTY) | out_a_ready;
   assign ready_path_b = (state_b_p1 == EMPTY) | out_b_ready;
   assign in_ready     = sel_a ? ready_path_a : ready_path_b;
   assign in_accept    = in_valid & in_ready;

   assign load_a = in_accept &  sel_a;
   assign load_b = in_accept & ~sel_a;
   assign fire_a = (state_a_p1 == FULL) & out_a_ready;
   assign fire_b = (state_b_p1 == FULL) & out_b_ready;

   // Stage p0 -> p1: holding registers and transfer counters
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_a_p1 <= EMPTY;
         state_b_p1 <= EMPTY;
         data_a_p1  <= '0;
         data_b_p1  <= '0;
         cnt_a_p1   <= '0;
         cnt_b_p1   <= '0;
      end else begin
         // A load while FULL only happens together with a fire, which keeps
         // the channel FULL with the new word (full-rate pass-through).
         if (load_a) begin
            data_a_p1  <= in_data;
            state_a_p1 <= FULL;
         end else if (fire_a) begin
            state_a_p1 <= EMPTY;
         end

         if (load_b) begin
            data_b_p1  <= in_data;
            state_b_p1 <= FULL;
         end else if (fire_b) begin
            state_b_p1 <= EMPTY;
         end

         if (fire_a)
            cnt_a_p1 <= sat_inc(cnt_a_p1);
         if (fire_b)
            cnt_b_p1 <= sat_inc(cnt_b_p1);
      end
   end

   assign out_a       = data_a_p1;
   assign out_b       = data_b_p1;
   assign out_a_valid = (state_a_p1 == FULL);
   assign out_b_valid = (state_b_p1 == FULL);
   assign cnt_a       = cnt_a_p1;
   assign cnt_b       = cnt_b_p1;

endmodule

// File: tb/tb_scale_demux.sv
// ---------------------------------------------------------------------------
// tb_scale_demux
//   Bench for scale_demux. A wide-counter instance (CNT_W=8) and a narrow one
//   (CNT_W=2) share the same stimulus. The driver pushes each accepted word
//   into a per-channel expected queue; a monitor compares outputs against the
//   queue heads and against transfer counts clipped to each counter's range.
// ---------------------------------------------------------------------------
module tb_scale_demux;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_ = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         sel_a = 1'b0;
   logic         out_a_ready = 1'b0;
   logic         out_b_ready = 1'b0;

   logic         in_ready, out_a_valid, out_b_valid;
   logic [W-1:0] out_a, out_b;
   logic [7:0]   cnt_a, cnt_b;

   logic         in_ready_s, out_a_valid_s, out_b_valid_s;
   logic [W-1:0] out_a_s, out_b_s;
   logic [1:0]   cnt_a_s, cnt_b_s;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] qa[$];
   logic [W-1:0] qb[$];
   int xfer_a = 0;
   int xfer_b = 0;

   always #5 clk = ~clk;

   scale_demux #(.WIDTH(W), .CNT_W(8)) dut (
      .clk(clk), .rst_(rst_), .in_data(in_data), .in_valid(in_valid),
      .sel_a(sel_a), .in_ready(in_ready),
      .out_a(out_a), .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
      .out_b(out_b), .out_b_valid(out_b_valid), .out_b_ready(out_b_ready),
      .cnt_a(cnt_a), .cnt_b(cnt_b)
   );

   scale_demux #(.WIDTH(W), .CNT_W(2)) dut_s (
      .clk(clk), .rst_(rst_), .in_data(in_data), .in_valid(in_valid),
      .sel_a(sel_a), .in_ready(in_ready_s),
      .out_a(out_a_s), .out_a_valid(out_a_valid_s), .out_a_ready(out_a_ready),
      .out_b(out_b_s), .out_b_valid(out_b_valid_s), .out_b_ready(out_b_ready),
      .cnt_a(cnt_a_s), .cnt_b(cnt_b_s)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int clip(input int v, input int m);
      return (v > m) ? m : v;
   endfunction

   // Monitor: one sample per cycle, after the driver has set this cycle's
   // inputs. Whatever fires at the coming edge is popped here.
   always @(negedge clk) begin
      #1;
      if (rst_) begin
         check("cnt_a", cnt_a, clip(xfer_a, 255));
         check("cnt_b", cnt_b, clip(xfer_b, 255));
         check("cnt_a_narrow", cnt_a_s, clip(xfer_a, 3));
         check("cnt_b_narrow", cnt_b_s, clip(xfer_b, 3));
         check("out_a_valid", out_a_valid, qa.size() != 0);
         check("out_b_valid", out_b_valid, qb.size() != 0);
         if (qa.size() != 0) begin
            check("out_a", out_a, qa[0]);
            if (out_a_ready) begin
               void'(qa.pop_front());
               xfer_a++;
            end
         end
         if (qb.size() != 0) begin
            check("out_b", out_b, qb[0]);
            if (out_b_ready) begin
               void'(qb.pop_front());
               xfer_b++;
            end
         end
      end
   end

   // One cycle of stimulus; also predicts in_ready and records accepted words.
   task automatic drive(input logic v, input logic s, input logic [W-1:0] d,
                        input logic ra, input logic rb);
      logic exp_rdy;
      @(negedge clk);
      in_valid = v; sel_a = s; in_data = d; out_a_ready = ra; out_b_ready = rb;
      #2;
      exp_rdy = s ? (qa.size() == 0 || ra) : (qb.size() == 0 || rb);
      check("in_ready", in_ready, exp_rdy);
      if (v && exp_rdy) begin
         if (s) qa.push_back(d);
         else   qb.push_back(d);
      end
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic pulse_reset();
      @(posedge clk);
      #3;
      rst_ = 1'b0;
      #1;
      check("rst_out_a_valid", out_a_valid, 1'b0);
      check("rst_out_b_valid", out_b_valid, 1'b0);
      check("rst_out_a", out_a, 8'h00);
      check("rst_out_b", out_b, 8'h00);
      check("rst_cnt_a", cnt_a, 8'h00);
      check("rst_cnt_b", cnt_b, 8'h00);
      qa.delete();
      qb.delete();
      xfer_a = 0;
      xfer_b = 0;
      in_valid = 1'b0;
      @(posedge clk);
      #3;
      rst_ = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not end, time %0t limit %0d", $time, 1_000_000);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] b_word;
      logic [1:0]   sat_exp[5];
      sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      // Power-on reset state
      #1;
      check("por_out_a_valid", out_a_valid, 1'b0);
      check("por_cnt_a", cnt_a, 8'h00);
      #12;
      rst_ = 1'b1;

      // Reset in the middle of a held transfer
      drive(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      check("held_5a_valid", out_a_valid, 1'b1);
      check("held_5a_data", out_a, 8'h5A);
      pulse_reset();
      repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      check("after_rst_cnt_a", cnt_a, 8'h00);

      // Steering
      pulse_reset();
      drive(1'b1, 1'b1, 8'h11, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 8'h22, 1'b1, 1'b1);
      check("steer_a_data", out_a, 8'h11);
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      check("steer_b_data", out_b, 8'h22);
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      check("steer_cnt_a", cnt_a, 8'd1);
      check("steer_cnt_b", cnt_b, 8'd1);

      // Backpressure on the selected channel
      pulse_reset();
      drive(1'b1, 1'b1, 8'h33, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 8'h44, 1'b0, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      drive(1'b1, 1'b1, 8'h44, 1'b0, 1'b1);
      check("bp_hold", out_a, 8'h33);
      drive(1'b1, 1'b1, 8'h44, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      check("bp_second", out_a, 8'h44);
      check("bp_cnt_a_1", cnt_a, 8'd1);
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      check("bp_cnt_a_2", cnt_a, 8'd2);

      // Stalled B does not block A
      pulse_reset();
      b_word = 8'(($urandom));
      drive(1'b1, 1'b0, b_word, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         drive(1'b1, 1'b1, 8'(($urandom)), 1'b1, 1'b0);
      repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      check("stall_cnt_a", cnt_a, 8'd4);
      check("stall_cnt_b", cnt_b, 8'd0);
      check("stall_out_b", out_b, b_word);
      check("stall_b_valid", out_b_valid, 1'b1);
      repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

      // Full throughput
      pulse_reset();
      for (int i = 0; i < 16; i++)
         drive(1'b1, 1'b1, 8'(($urandom)), 1'b1, 1'b1);
      repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      check("tput_cnt_a", cnt_a, 8'd16);

      // Narrow counter saturation on B
      pulse_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 8'(($urandom)), 1'b1, 1'b1);
         drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
         drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
         check("sat_cnt_b", cnt_b_s, sat_exp[i]);
      end

      // Random traffic, long enough to saturate the wide counters too
      pulse_reset();
      for (int i = 0; i < 2500; i++)
         drive(1'(($urandom_range(0, 3) != 0)), 1'(($urandom)), 8'(($urandom)),
               1'(($urandom_range(0, 3) != 0)), 1'(($urandom_range(0, 2) != 0)));
      repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      check("rand_drained_a", out_a_valid, 1'b0);
      check("rand_drained_b", out_b_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
